d_array: RTL and testbench
==========================

// Module: d_array
// PURPOSE
//  - Five-stage serial D-flip-flop chain (delay line / token shifter).
//  - A pulse on start enters stage 1 and advances one stage per rising clk edge, appearing on q1..q5 in turn.
//  - Used as a small sequencing/timing generator: qN asserts N cycles after start is sampled.
// PARAMETERS
//  - RESET_VAL  5'b00000  value loaded into {q5,q4,q3,q2,q1} on reset; bit0 -> q1.
// PORTS
//  - clk    in  1  rising-edge clock; single clock domain.
//  - reset  in  1  synchronous reset, active-high, sampled on rising clk.
//  - start  in  1  serial data in; sampled on rising clk into stage 1.
//  - q1     out 1  stage 1 register output.
//  - q2     out 1  stage 2 register output.
//  - q3     out 1  stage 3 register output.
//  - q4     out 1  stage 4 register output.
//  - q5     out 1  stage 5 register output (last stage).
// BEHAVIOUR
//  - All outputs driven directly from flops; no combinational path from any input to any output.
//  - Edge N with reset=1: {q5..q1} <= RESET_VAL; start ignored on that edge.
//  - Edge N with reset=0: q1<=start, q2<=q1, q3<=q2, q4<=q3, q5<=q4 (all sampled pre-edge values).
//  - Latency: start sampled high at edge N -> q1 high after N, q2 after N+1, ..., q5 after N+4.
//  - Pulse width preserved: start high for K edges -> each qi high for exactly K edges, offset i-1.
//  - Bit shifted out of q5 is discarded (unless D_ARRAY_RING_EN).
//  - Reset mid-operation: chain cleared on that edge; in-flight bits lost; shifting resumes from the first edge with reset=0.
//  - reset and start both high on same edge: reset wins, q1 = RESET_VAL[0].
//  - Before the first reset edge, flop contents are undefined (no initial blocks relied upon).
//  - Asynchronous changes of start/reset between edges have no effect on outputs.
// CONFIGURATION
//  - D_ARRAY_RING_EN defined: recirculating ring; q1 <= start | q5, so a token loops q1->q5->q1 with period 5 until reset.
//  - D_ARRAY_RING_EN undefined (default): open chain; q1 <= start, q5 output dropped.
//  - Reset behaviour and all other rules are identical in both builds.
// TESTING
//  - Reset: hold reset=1 over one rising edge -> q1..q5 = 0 (RESET_VAL default); hold start=0 afterwards -> all stay 0.
//  - Single pulse: start=1 for one edge (E0), then 0 -> q1 high after E0, q2 after E1, ..., q5 after E4; exactly one qi high at a time; all 0 after E5.
//  - Wide pulse: start=1 for 3 edges -> each qi high for exactly 3 cycles, qi rising one cycle after q(i-1).
//  - Reset mid-flight: pulse in q3, assert reset on next edge -> all 0; no further activity after deassert.
//  - Priority: reset=1 and start=1 on same edge -> q1=0; start=1 on next edge with reset=0 -> q1=1.
//  - Ring (D_ARRAY_RING_EN): single start pulse -> q1 high again 5 edges after first (q5 feeds q1); reset stops the loop.

Source files
------------

// File: rtl/d_array.sv
// Five-stage serial D flip-flop chain used as a delay line and token shifter.
// Defining D_ARRAY_RING_EN closes the chain into a ring, so stage 5 feeds back into stage 1.
module d_array #(
  parameter logic [4:0] RESET_VAL = 5'b00000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic q1,
  output logic q2,
  output logic q3,
  output logic q4,
  output logic q5
);

  localparam int STAGES = 5;

  // Bit 0 of chain_p0 is stage 1 (q1) and bit STAGES-1 is the last stage (q5).
  logic [STAGES-1:0] chain_p0;
  logic              feed;

`ifdef D_ARRAY_RING_EN
  assign feed = start | chain_p0[STAGES-1];
`else
  assign feed = start;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_p0 <= RESET_VAL;
    end else begin
      chain_p0 <= {chain_p0[STAGES-2:0], feed};
    end
  end

  assign q1 = chain_p0[0];
  assign q2 = chain_p0[1];
  assign q3 = chain_p0[2];
  assign q4 = chain_p0[3];
  assign q5 = chain_p0[4];

endmodule

// File: tb/tb_d_array.sv
// Directed-vector bench for d_array. Each vector gives reset, start and the expected {q5..q1} after the edge.
// If D_ARRAY_RING_EN is defined, the bench uses the vector table for the ring build.
module tb_d_array;

  logic clk;
  logic reset;
  logic start;
  logic q1, q2, q3, q4, q5;

  int n_checks;
  int n_fail;

  d_array dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .q1    (q1),
    .q2    (q2),
    .q3    (q3),
    .q4    (q4),
    .q5    (q5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: q5..q1 got %b want %b", tag, obs, exp);
    end
  endtask

  // Vector layout: {reset, start, expected q5..q1}
`ifdef D_ARRAY_RING_EN
  localparam int NV = 17;
  logic [6:0] vecs [NV] = '{
    7'b10_00000, 7'b00_00000,
    7'b01_00001, 7'b00_00010, 7'b00_00100, 7'b00_01000, 7'b00_10000,
    7'b00_00001, 7'b00_00010,
    7'b10_00000, 7'b00_00000, 7'b00_00000,
    7'b11_00000, 7'b01_00001, 7'b00_00010, 7'b10_00000, 7'b00_00000
  };
`else
  localparam int NV = 28;
  logic [6:0] vecs [NV] = '{
    7'b10_00000, 7'b00_00000, 7'b00_00000,
    7'b01_00001, 7'b00_00010, 7'b00_00100, 7'b00_01000, 7'b00_10000,
    7'b00_00000, 7'b00_00000,
    7'b01_00001, 7'b01_00011, 7'b01_00111, 7'b00_01110, 7'b00_11100,
    7'b00_11000, 7'b00_10000, 7'b00_00000,
    7'b01_00001, 7'b00_00010, 7'b00_00100, 7'b10_00000, 7'b00_00000,
    7'b00_00000,
    7'b11_00000, 7'b01_00001, 7'b00_00010, 7'b10_00000
  };
`endif

  initial begin
    logic [6:0] v;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(negedge clk);
      reset = v[6];
      start = v[5];
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {q5, q4, q3, q2, q1}, v[4:0]);
      // A glitch on start between edges must not reach the outputs.
      if (i == 4) begin
        start = ~start;
        #2;
        chk("async_start", {q5, q4, q3, q2, q1}, v[4:0]);
        start = ~start;
      end
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
